debounce_sync: RTL and testbench

//   Conditions a raw asynchronous level (push-button, external pin) into a clean, clk-synchronous level.
//   Two steps: a SYNC_STAGES flop synchronizer, then a 4-state debounce FSM with a stability counter.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_ff.sv | 23 ++
 rtl/debounce_sync.sv | 110 +++++++++++
 tb/tb_debounce_sync.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default sizing for the debounce synchronizer
package debounce_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } dbc_state_t;

    function automatic logic is_wait(input dbc_state_t st);
        return (st == WAIT_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-flop level synchronizer with asynchronous active-low clear to 0
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus 4-state debounce FSM producing a clean level y
// Optional count-enable tick port when DEBOUNCE_TICK_EN is defined.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic x_raw,
`ifdef DEBOUNCE_TICK_EN
    input  logic tick,
`endif
    output logic y,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic             en;
    dbc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (x_raw),
        .q       (s)
    );

`ifdef DEBOUNCE_TICK_EN
    assign en = tick;
`else
    assign en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    // A revert of s is checked before en so a bounce on a tick cycle never counts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE_HIGH;
                        y_d     = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE_LOW;
                        y_d     = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE_LOW;
                y_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign y    = y_q;
    assign busy = is_wait(state_q);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed self-checking bench for debounce_sync (tick test under DEBOUNCE_TICK_EN)
module tb_debounce_sync;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk;
    logic reset_n;
    logic x_raw;
`ifdef DEBOUNCE_TICK_EN
    logic tick;
`endif
    logic y;
    logic busy;

    int checks = 0;
    int errors = 0;

    debounce_sync #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x_raw   (x_raw),
`ifdef DEBOUNCE_TICK_EN
        .tick    (tick),
`endif
        .y       (y),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        x_raw   = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (y !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_assert got y=%b busy=%b want y=0 busy=0", y, busy);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (y !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle edge %0d got y=%b busy=%b want y=0 busy=0", k, y, busy);
            end
        end
    endtask

    task automatic test_rise();
        x_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (y !== 1'((k >= 7)) || busy !== 1'((k >= 3) && (k <= 6))) begin
                errors++;
                $display("FAIL rise edge %0d got y=%b busy=%b want y=%b busy=%b",
                         k, y, busy, (k >= 7), ((k >= 3) && (k <= 6)));
            end
        end
    endtask

    task automatic test_fall();
        x_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (y !== 1'((k < 7)) || busy !== 1'((k >= 3) && (k <= 6))) begin
                errors++;
                $display("FAIL fall edge %0d got y=%b busy=%b want y=%b busy=%b",
                         k, y, busy, (k < 7), ((k >= 3) && (k <= 6)));
            end
        end
    endtask

    task automatic test_glitch();
        logic ey, eb;
        for (int k = 1; k <= 10; k++) begin
            x_raw = (k <= 3);
            step();
            eb = (k >= 3) && (k <= 5);
            checks++;
            if (y !== 1'b0 || busy !== eb) begin
                errors++;
                $display("FAIL glitch3 edge %0d got y=%b busy=%b want y=0 busy=%b", k, y, busy, eb);
            end
        end
        // 5-cycle pulse just qualifies, then its fall is debounced back to 0
        for (int k = 1; k <= 13; k++) begin
            x_raw = (k <= 5);
            step();
            ey = (k >= 7) && (k <= 11);
            eb = ((k >= 3) && (k <= 6)) || ((k >= 8) && (k <= 11));
            checks++;
            if (y !== ey || busy !== eb) begin
                errors++;
                $display("FAIL pulse5 edge %0d got y=%b busy=%b want y=%b busy=%b", k, y, busy, ey, eb);
            end
        end
    endtask

    task automatic test_bounce();
        logic ey, eb;
        x_raw = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        checks++;
        if (y !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_setup got y=%b busy=%b want y=1 busy=0", y, busy);
        end
        for (int k = 1; k <= 16; k++) begin
            x_raw = ((k >= 3) && (k <= 4)) || ((k >= 7) && (k <= 8));
            step();
            ey = (k < 15);
            eb = (k == 3) || (k == 4) || (k == 7) || (k == 8) || ((k >= 11) && (k <= 14));
            checks++;
            if (y !== ey || busy !== eb) begin
                errors++;
                $display("FAIL bounce edge %0d got y=%b busy=%b want y=%b busy=%b", k, y, busy, ey, eb);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        x_raw = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if (busy !== 1'b1 || y !== 1'b0) begin
            errors++;
            $display("FAIL midwait_setup got y=%b busy=%b want y=0 busy=1", y, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || y !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset got y=%b busy=%b want y=0 busy=0", y, busy);
        end
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (y !== 1'((k >= 7)) || busy !== 1'((k >= 3) && (k <= 6))) begin
                errors++;
                $display("FAIL after_reset edge %0d got y=%b busy=%b want y=%b busy=%b",
                         k, y, busy, (k >= 7), ((k >= 3) && (k <= 6)));
            end
        end
    endtask

`ifdef DEBOUNCE_TICK_EN
    task automatic test_tick();
        logic eb;
        reset_n = 1'b0;
        x_raw   = 1'b0;
        tick    = 1'b0;
        step();
        reset_n = 1'b1;
        x_raw   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick = ((k % 3) == 0);
            step();
            checks++;
            if (y !== 1'((k >= 15)) || busy !== 1'((k >= 3) && (k <= 14))) begin
                errors++;
                $display("FAIL tick_rise edge %0d got y=%b busy=%b want y=%b busy=%b",
                         k, y, busy, (k >= 15), ((k >= 3) && (k <= 14)));
            end
        end
        reset_n = 1'b0;
        tick    = 1'b0;
        x_raw   = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            x_raw = (k <= 6);
            tick  = ((k % 3) == 0);
            step();
            eb = (k >= 3) && (k <= 8);
            checks++;
            if (y !== 1'b0 || busy !== eb) begin
                errors++;
                $display("FAIL tick_revert edge %0d got y=%b busy=%b want y=0 busy=%b", k, y, busy, eb);
            end
        end
        tick = 1'b1;
    endtask
`endif

    initial begin
`ifdef DEBOUNCE_TICK_EN
        tick = 1'b1;
`endif
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
`ifdef DEBOUNCE_TICK_EN
        test_tick();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
